sha256_nonce_sched: RTL
=======================

# sha256_nonce_sched

Nonce-sweep controller for the double-SHA-256 core. Accepts a mining job (nonce range plus 256-bit compare target), drives one nonce per clock into the fixed-latency hashing pipeline, and tracks in-flight nonces with a valid delay line. Compares each returning hash against the target and queues winning nonces in a 2-entry result FIFO for the host-side interface.

## Interface
- PIPE_LAT, 130, cycles from core_nonce sampled to matching core_hash valid (>= 2)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- job_valid  in  1  job offered
- job_ready  out  1  scheduler can accept a job
- job_nonce_start  in  32  first nonce of sweep
- job_nonce_end  in  32  last nonce of sweep (inclusive)
- job_target  in  256  hit if core_hash <= job_target (unsigned)
- abort  in  1  cancel current job
- core_nonce  out  32  nonce fed to hashing core
- core_valid  out  1  core_nonce is a live issue this cycle
- core_hash  in  256  hash2 from core, aligned PIPE_LAT cycles after issue
- result_valid  out  1  FIFO head valid
- result_ready  in  1  consumer pops head
- result_nonce  out  32  winning nonce at FIFO head
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse: sweep finished, all in-flight returned
- hit_dropped  out  1  sticky: a hit was lost to a full FIFO

## Operation
- States IDLE, SWEEP, DRAIN.
- IDLE: job_ready=1. job_valid at edge: latch start/end/target, clear hit_dropped, issue pointer = start, return pointer = start, go SWEEP.
- SWEEP: core_valid=1, core_nonce=issue pointer; pointer += 1 mod 2^32 each cycle. Cycle issuing nonce == end: go DRAIN.
- Range wraps: end < start sweeps through 0xFFFFFFFF to 0. end == start: one nonce. end == start-1: full 2^32 sweep.
- Delay line: PIPE_LAT-bit shift register of core_valid. Its output marks core_hash as live; return pointer increments on each live return, giving the nonce belonging to core_hash.
- Hit: live return with core_hash <= target (256-bit unsigned) pushes return pointer into FIFO. FIFO full (2 entries, no simultaneous pop): drop, set hit_dropped.
- Push and pop in the same cycle on a full FIFO are both accepted.
- DRAIN: core_valid=0. When the delay line holds no live bits: done=1 for one cycle, go IDLE. FIFO contents are not waited on.
- abort in SWEEP/DRAIN: next cycle IDLE, delay line cleared, no done pulse. FIFO and hit_dropped retained. abort in IDLE ignored.
- job_valid is ignored outside IDLE.

## Timing
- Reset values: job_ready=1, core_valid=0, core_nonce=0, result_valid=0, result_nonce=0, busy=0, done=0, hit_dropped=0. Delay line and FIFO are empty.
- Job accepted at edge T: core_valid=1 with core_nonce=start from cycle T+1. The last nonce issues at T+N, where N = (end-start mod 2^32)+1.
- Nonce issued in cycle k: its hash is compared in cycle k+PIPE_LAT. On a hit, result_valid is high from cycle k+PIPE_LAT+1.
- done is high in cycle T+N+PIPE_LAT+1. IDLE and job_ready=1 follow in the next cycle.
- Back-to-back jobs: minimum gap is one IDLE cycle.
- result_valid/result_ready: pop on an edge where both are high. result_nonce is stable while valid && !ready.
- Reset mid-sweep: all state returns to reset values asynchronously.

## Test plan
- PIPE_LAT=4, start=0x10, end=0x13, target=all-ones: 4 hits, core_valid high 4 cycles, result_ready=1. Results 0x10..0x13 in order; done 9 cycles after accept; hit_dropped=0.
- Wrap: start=0xFFFFFFFE, end=0x1, target=0, model hashes 0 only for nonce 0x0. Core sees FFFFFFFE, FFFFFFFF, 0, 1; single result 0x0.
- Backpressure: 4 hits with result_ready=0. FIFO holds first 2 nonces, hit_dropped=1. Releasing ready yields exactly 2 results. Next job clears hit_dropped.
- Abort mid-sweep at nonce 5 of 10: core_valid drops next cycle, no done, state IDLE. In-flight hits do not appear; a new job is accepted immediately.
- Compare boundary: core_hash == target gives a hit; target+1 gives no hit.
- Async reset asserted mid-DRAIN with FIFO non-empty: all outputs at reset values within the reset cycle, result_valid=0.

Source files
------------

// File: rtl/sha256_nonce_sched.sv
// sha256_nonce_sched
// Nonce-sweep controller for the double-SHA-256 core. It accepts a job (nonce
// range plus a 256-bit compare target) and issues one nonce per clock to a
// fixed-latency hashing pipeline. A valid delay line tracks which nonces are
// still in flight. Each returning hash is compared against the target, and
// winning nonces go into a 2-entry result FIFO.
//
// Ports
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   job_valid/ready    job handshake; accepted only in IDLE
//   job_nonce_start    first nonce of the sweep
//   job_nonce_end      last nonce of the sweep (inclusive, may wrap)
//   job_target         hit when core_hash <= job_target (unsigned)
//   abort              cancel the running job (ignored in IDLE)
//   core_nonce/valid   nonce issue toward the hashing core
//   core_hash          core result, PIPE_LAT cycles after issue
//   result_valid/ready/nonce   FIFO head handshake
//   busy               scheduler not idle
//   done               one-cycle pulse once the sweep has fully drained
//   hit_dropped        sticky flag: a hit was lost to a full FIFO
module sha256_nonce_sched #(
  parameter int unsigned PIPE_LAT = 130
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         job_valid,
  output logic         job_ready,
  input  logic [31:0]  job_nonce_start,
  input  logic [31:0]  job_nonce_end,
  input  logic [255:0] job_target,
  input  logic         abort,
  output logic [31:0]  core_nonce,
  output logic         core_valid,
  input  logic [255:0] core_hash,
  output logic         result_valid,
  input  logic         result_ready,
  output logic [31:0]  result_nonce,
  output logic         busy,
  output logic         done,
  output logic         hit_dropped
);

  localparam int unsigned NONCE_W = 32;
  localparam int unsigned HASH_W  = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, state_next;

  // Latched job parameters
  logic [NONCE_W-1:0]  job_end,    job_end_next;
  logic [HASH_W-1:0]   job_tgt,    job_tgt_next;

  // Issue/return tracking
  logic [NONCE_W-1:0]  ret_ptr,    ret_ptr_next;
  logic [PIPE_LAT-1:0] dl,         dl_next;
  logic [NONCE_W-1:0]  core_nonce_next;
  logic                core_valid_next;

  // Result FIFO: head register drives the outputs directly, tail is the spill slot
  logic [NONCE_W-1:0]  head_next;
  logic                head_v_next;
  logic [NONCE_W-1:0]  tail,       tail_next;
  logic                tail_v,     tail_v_next;

  logic                job_ready_next;
  logic                busy_next;
  logic                done_next;
  logic                hit_dropped_next;

  logic                accept;
  logic                kill;
  logic                live;
  logic                hit;
  logic                pop;
  logic                push;
  logic                drop;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state, datapath and output decode
  always_comb begin
    state_next       = state;
    accept           = 1'b0;
    kill             = 1'b0;
    job_end_next     = job_end;
    job_tgt_next     = job_tgt;
    ret_ptr_next     = ret_ptr;
    core_nonce_next  = core_nonce;
    head_next        = result_nonce;
    head_v_next      = result_valid;
    tail_next        = tail;
    tail_v_next      = tail_v;
    hit_dropped_next = hit_dropped;

    case (state)
      IDLE: begin
        if (job_valid) begin
          state_next = SWEEP;
          accept     = 1'b1;
        end
      end
      SWEEP: begin
        if (abort) begin
          state_next = IDLE;
          kill       = 1'b1;
        end else if (core_nonce == job_end) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (abort) begin
          state_next = IDLE;
          kill       = 1'b1;
        end else if (dl == '0) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Delay line mirrors core_valid so its MSB marks core_hash as live
    dl_next = kill ? '0 : {dl[PIPE_LAT-2:0], core_valid};

    // The cycle in which the last live bit leaves the line arms the done pulse
    done_next = (state == DRAIN) && !abort && (dl != '0) && (dl_next == '0);

    // An aborting cycle also discards the hash returning in that cycle
    live = dl[PIPE_LAT-1] && !kill;
    hit  = live && (core_hash <= job_tgt);
    pop  = result_valid && result_ready;
    push = hit && (!tail_v || pop);
    drop = hit && tail_v && !pop;

    if (accept) begin
      job_end_next     = job_nonce_end;
      job_tgt_next     = job_target;
      ret_ptr_next     = job_nonce_start;
      core_nonce_next  = job_nonce_start;
      hit_dropped_next = 1'b0;
    end else begin
      if (live) begin
        ret_ptr_next = ret_ptr + NONCE_W'(1);
      end
      if (state == SWEEP && state_next == SWEEP) begin
        core_nonce_next = core_nonce + NONCE_W'(1);
      end
      if (drop) begin
        hit_dropped_next = 1'b1;
      end
    end

    // FIFO update; a full FIFO accepts a push when it pops in the same cycle
    if (pop && push) begin
      if (tail_v) begin
        head_next   = tail;
        head_v_next = 1'b1;
        tail_next   = ret_ptr;
        tail_v_next = 1'b1;
      end else begin
        head_next   = ret_ptr;
        head_v_next = 1'b1;
      end
    end else if (pop) begin
      head_next   = tail_v ? tail : result_nonce;
      head_v_next = tail_v;
      tail_v_next = 1'b0;
    end else if (push) begin
      if (!result_valid) begin
        head_next   = ret_ptr;
        head_v_next = 1'b1;
      end else begin
        tail_next   = ret_ptr;
        tail_v_next = 1'b1;
      end
    end

    core_valid_next = (state_next == SWEEP);
    job_ready_next  = (state_next == IDLE);
    busy_next       = (state_next != IDLE);
  end

  // Registered datapath and outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      job_end      <= '0;
      job_tgt      <= '0;
      ret_ptr      <= '0;
      dl           <= '0;
      core_nonce   <= '0;
      core_valid   <= 1'b0;
      result_nonce <= '0;
      result_valid <= 1'b0;
      tail         <= '0;
      tail_v       <= 1'b0;
      job_ready    <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      hit_dropped  <= 1'b0;
    end else begin
      job_end      <= job_end_next;
      job_tgt      <= job_tgt_next;
      ret_ptr      <= ret_ptr_next;
      dl           <= dl_next;
      core_nonce   <= core_nonce_next;
      core_valid   <= core_valid_next;
      result_nonce <= head_next;
      result_valid <= head_v_next;
      tail         <= tail_next;
      tail_v       <= tail_v_next;
      job_ready    <= job_ready_next;
      busy         <= busy_next;
      done         <= done_next;
      hit_dropped  <= hit_dropped_next;
    end
  end

endmodule
